// File: rtl/stopwatch_ctrl_if.sv
// rtl/stopwatch_ctrl_if.sv - button, overflow and core-control bundle for stopwatch_ctrl
//
// Signals:
//   btn_start_n, btn_lap_n, btn_clr_n  raw active-low push-buttons (asynchronous)
//   stopwatch_overflow                  core overflow flag, level, active high
//   start_stop                          to core: 0 = count, 1 = stopped
//   hold                                to core: 0 = freeze display, counting continues
//   sw_clear_n                          to core: active-low clear
//   ctrl_state                          current controller state code
//   lap_count                           laps taken since the last clear
// Modports: master = the controller, slave = board pins plus counter core.

interface stopwatch_ctrl_if #(
   parameter int LAP_W = 4
);
   logic             btn_start_n;
   logic             btn_lap_n;
   logic             btn_clr_n;
   logic             stopwatch_overflow;
   logic             start_stop;
   logic             hold;
   logic             sw_clear_n;
   logic [2:0]       ctrl_state;
   logic [LAP_W-1:0] lap_count;

   modport master (
      input  btn_start_n, btn_lap_n, btn_clr_n, stopwatch_overflow,
      output start_stop, hold, sw_clear_n, ctrl_state, lap_count
   );

   modport slave (
      output btn_start_n, btn_lap_n, btn_clr_n, stopwatch_overflow,
      input  start_stop, hold, sw_clear_n, ctrl_state, lap_count
   );
endinterface

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - stopwatch front-panel controller: button conditioning and mode FSM
//
// Ports:
//   CLK_100Hz  input   100 Hz clock, rising edge
//   reset_n    input   asynchronous active-low reset
//   bus        master  stopwatch_ctrl_if: raw buttons and overflow in,
//                      start_stop / hold / sw_clear_n / ctrl_state / lap_count out

module stopwatch_ctrl #(
   parameter int DEBOUNCE_TICKS = 5,
   parameter int CLEAR_TICKS    = 2,
   parameter int LAP_W          = 4
) (
   input  logic           CLK_100Hz,
   input  logic           reset_n,
   stopwatch_ctrl_if.master bus
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RUN   = 3'd1,
      S_STOP  = 3'd2,
      S_LAP   = 3'd3,
      S_OVF   = 3'd4,
      S_CLEAR = 3'd5
   } state_t;

   // Button index: 0 = start, 1 = lap, 2 = clear.
   logic [2:0] w_raw;
   logic [2:0] r_sync1;
   logic [2:0] r_sync2;
   logic [2:0] r_deb;
   logic [2:0] r_press;
   logic [7:0] r_cnt [3];

   state_t           r_state;
   state_t           w_next;
   logic             r_start_stop;
   logic             r_hold;
   logic             r_clear_n;
   logic [LAP_W-1:0] r_lap;
   logic [3:0]       r_clr_tmr;

   logic w_start;
   logic w_lap;
   logic w_clr;

   assign w_raw = {bus.btn_clr_n, bus.btn_lap_n, bus.btn_start_n};

   // Two-flop synchroniser, then a run-length debounce: the debounced level
   // only follows the synced value after DEBOUNCE_TICKS consecutive
   // disagreeing cycles. The press pulse is registered on the 1->0 update.
   always_ff @(posedge CLK_100Hz or negedge reset_n) begin
      if (!reset_n) begin
         r_sync1 <= 3'b111;
         r_sync2 <= 3'b111;
         r_deb   <= 3'b111;
         r_press <= 3'b000;
         for (int i = 0; i < 3; i++) begin
            r_cnt[i] <= 8'd0;
         end
      end else begin
         r_sync1 <= w_raw;
         r_sync2 <= r_sync1;
         r_press <= 3'b000;
         for (int i = 0; i < 3; i++) begin
            if (r_sync2[i] == r_deb[i]) begin
               r_cnt[i] <= 8'd0;
            end else if (r_cnt[i] == 8'(DEBOUNCE_TICKS - 1)) begin
               r_deb[i]   <= r_sync2[i];
               r_cnt[i]   <= 8'd0;
               r_press[i] <= ~r_sync2[i];
            end else begin
               r_cnt[i] <= r_cnt[i] + 8'd1;
            end
         end
      end
   end

   assign w_start = r_press[0];
   assign w_lap   = r_press[1];
   assign w_clr   = r_press[2];

   // Priority within a cycle: overflow > clear > start > lap. Events that a
   // state does not list are simply dropped.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_clr)        w_next = S_CLEAR;
            else if (w_start) w_next = S_RUN;
         end
         S_RUN: begin
            if (bus.stopwatch_overflow) w_next = S_OVF;
            else if (w_start)           w_next = S_STOP;
            else if (w_lap)             w_next = S_LAP;
         end
         S_LAP: begin
            if (bus.stopwatch_overflow) w_next = S_OVF;
            else if (w_start)           w_next = S_STOP;
            else if (w_lap)             w_next = S_RUN;
         end
         S_STOP: begin
            if (w_clr)        w_next = S_CLEAR;
            else if (w_start) w_next = S_RUN;
         end
         S_OVF: begin
            if (w_clr) w_next = S_CLEAR;
         end
         S_CLEAR: begin
            if (r_clr_tmr == 4'd0) w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they change on the same
   // edge as ctrl_state and come straight from flops.
   always_ff @(posedge CLK_100Hz or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= S_IDLE;
         r_start_stop <= 1'b1;
         r_hold       <= 1'b1;
         r_clear_n    <= 1'b1;
         r_lap        <= '0;
         r_clr_tmr    <= 4'd0;
      end else begin
         r_state      <= w_next;
         r_start_stop <= !((w_next == S_RUN) || (w_next == S_LAP));
         r_hold       <= (w_next != S_LAP);
         r_clear_n    <= (w_next != S_CLEAR);

         // Timer loads CLEAR_TICKS-1 on entry so clear is held exactly CLEAR_TICKS cycles.
         if ((w_next == S_CLEAR) && (r_state != S_CLEAR)) begin
            r_clr_tmr <= 4'(CLEAR_TICKS - 1);
            r_lap     <= '0;
         end else begin
            if (r_clr_tmr != 4'd0) begin
               r_clr_tmr <= r_clr_tmr - 4'd1;
            end
            if ((r_state == S_RUN) && (w_next == S_LAP) && (r_lap != {LAP_W{1'b1}})) begin
               r_lap <= r_lap + LAP_W'(1);
            end
         end
      end
   end

   assign bus.start_stop = r_start_stop;
   assign bus.hold       = r_hold;
   assign bus.sw_clear_n = r_clear_n;
   assign bus.ctrl_state = r_state;
   assign bus.lap_count  = r_lap;

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Front-panel controller that sequences the stopwatch counter core (mins/secs/decs) from three raw push-buttons. It synchronises and debounces the buttons and runs a mode state machine. It drives the core's active-low start_stop, hold and clear controls, and reacts to the core's overflow flag. It sits between the board button pins and the counter core, and shares the 100 Hz clock and global reset with the core.

Parameters:
DEBOUNCE_TICKS, 5, consecutive stable cycles before a debounced level changes (50 ms at 100 Hz); legal range 1..255
CLEAR_TICKS, 2, cycles sw_clear_n is held low when clearing the core; legal range 1..15
LAP_W, 4, width of the saturating lap counter

Ports:
CLK_100Hz  input  1  100 Hz system clock; all logic on rising edge
reset_n  input  1  asynchronous, active-low reset
btn_start_n  input  1  raw start/stop button, active low, asynchronous to the clock
btn_lap_n  input  1  raw lap/hold button, active low, asynchronous
btn_clr_n  input  1  raw clear button, active low, asynchronous
stopwatch_overflow  input  1  core overflow flag, level, active high
start_stop  output  1  to core; 0 = count, 1 = stopped
hold  output  1  to core; 0 = freeze displayed value while counting continues
sw_clear_n  output  1  to core clear/reset; active low
ctrl_state  output  3  current FSM state code
lap_count  output  LAP_W  number of laps taken since the last clear

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state=IDLE; start_stop=1; hold=1; sw_clear_n=1; lap_count=0.
  - Synchroniser flops=1, debounced levels=1, debounce counters=0, clear timer=0.
- Input conditioning, per button, identical logic:
  - 2-flop synchroniser feeds a debounce counter.
  - Counter increments while the synced value differs from the debounced level. It resets to 0 whenever they match.
  - On reaching DEBOUNCE_TICKS, the debounced level takes the synced value and the counter resets.
  - A press event is a 1-cycle pulse on the debounced 1->0 transition. Release produces no event.
  - Glitches shorter than DEBOUNCE_TICKS cycles produce no event.
- Press latency: raw low first sampled at edge N -> press pulse valid during cycle N+1+DEBOUNCE_TICKS. FSM outputs update at the following edge. With the default, total latency from raw edge to start_stop change is DEBOUNCE_TICKS+2 = 7 edges.
- All outputs are registered and decoded from the registered state. No combinational path from inputs to outputs.
- States and codes: IDLE=0, RUN=1, STOP=2, LAP=3, OVF=4, CLEAR=5. Codes 6/7 are illegal and recover to IDLE on the next edge.
- Outputs per state:
  - start_stop=0 in RUN and LAP; 1 in all other states.
  - hold=0 in LAP only.
  - sw_clear_n=0 in CLEAR only.
- Transitions. Per-cycle priority: overflow > clr > start > lap. One transition per cycle; lower-priority events in the same cycle are discarded.
  - IDLE: start -> RUN; clr -> CLEAR; lap ignored.
  - RUN: overflow -> OVF; start -> STOP; lap -> LAP; clr ignored.
  - LAP: overflow -> OVF; start -> STOP (hold released, final value shown); lap -> RUN; clr ignored.
  - STOP: clr -> CLEAR; start -> RUN; lap ignored.
  - OVF: clr -> CLEAR; start, lap and further overflow ignored.
  - CLEAR: timer loads CLEAR_TICKS-1 on entry and decrements each cycle. At 0 -> IDLE, so sw_clear_n is low for exactly CLEAR_TICKS cycles. All button events are ignored in CLEAR.
- Overflow:
  - Sampled as a level only in RUN and LAP.
  - If stopwatch_overflow is still high on return to IDLE, it is ignored until the next RUN.
- lap_count:
  - +1 on every RUN->LAP transition; saturates at 2^LAP_W-1 (no wrap).
  - Cleared to 0 on entry to CLEAR.
  - LAP->RUN does not count.
- Reset mid-operation: any state, any counter value -> immediate reset values. Buttons held low through reset deassertion are debounced afresh and produce one press event.

Test Plan:
- Reset, then btn_start_n low for 20 cycles -> start_stop 1->0 exactly 7 edges after the first sampled low; ctrl_state=1; hold=1; lap_count=0.
- In RUN, btn_lap_n low for 4 cycles (glitch) -> no change. Low for 10 cycles -> ctrl_state=3, hold=0, start_stop=0, lap_count=1. Second lap press -> ctrl_state=1, hold=1, lap_count=1.
- In LAP, press start -> ctrl_state=2, start_stop=1, hold=1. Press lap -> no change. Press clr -> sw_clear_n=0 for exactly 2 cycles, then ctrl_state=0 and lap_count=0.
- In RUN, raise stopwatch_overflow in the same cycle as a start press event -> ctrl_state=4, start_stop=1. Start and lap presses are ignored; a clr press -> CLEAR -> IDLE.
- With LAP_W=2, perform 5 RUN->LAP->RUN cycles -> lap_count reads 1, 2, 3, 3, 3.
- Assert reset_n low in LAP with lap_count=2 and a debounce count in progress -> outputs immediately start_stop=1, hold=1, sw_clear_n=1, ctrl_state=0, lap_count=0. No press event after release unless the button is still held.
